// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline register with opcode
// pre-decode, stall/redirect handling and a halt state for out-of-range PCs.
//
// Ports:
//   clk, rst_n          - clock and asynchronous active-low reset
//   mem_addr            - word address (current PC) to instruction memory
//   mem_data            - instruction word for mem_addr, same cycle
//   stall               - hold PC and IF/ID contents
//   redirect_valid      - load redirect_target into PC and insert a bubble
//   redirect_target     - word address for the redirect
//   ifid_valid          - IF/ID holds a real instruction
//   ifid_instr/npc      - latched instruction word and its PC+1
//   ifid_class          - registered opcode class
//   halted              - fetch stopped because PC ran past MEM_DEPTH
//   fetch_count         - number of instructions captured (wraps)
module instr_fetch #(
    parameter int unsigned MEM_DEPTH = 128,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_npc,
    output logic [2:0]  ifid_class,
    output logic        halted,
    output logic [15:0] fetch_count
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned CLS_W = 3;
    localparam int unsigned OPC_W = 6;

    localparam logic [XLEN-1:0] DEPTH_LIMIT = XLEN'(MEM_DEPTH);
    localparam logic [XLEN-1:0] PC_RESET    = XLEN'(RESET_PC);

    localparam logic [CLS_W-1:0] CLS_RTYPE = 3'b000;
    localparam logic [CLS_W-1:0] CLS_BEQ   = 3'b001;
    localparam logic [CLS_W-1:0] CLS_LW    = 3'b010;
    localparam logic [CLS_W-1:0] CLS_SW    = 3'b011;
    localparam logic [CLS_W-1:0] CLS_OTHER = 3'b111;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    logic [XLEN-1:0]   npc_q, npc_d;
    logic [CLS_W-1:0]  class_q, class_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Opcode (instr[31:26]) to instruction class.
    function automatic logic [CLS_W-1:0] predecode(input logic [OPC_W-1:0] opc);
        logic [CLS_W-1:0] cls;
        cls = CLS_OTHER;
        unique case (opc)
            6'h00:   cls = CLS_RTYPE;
            6'h04:   cls = CLS_BEQ;
            6'h23:   cls = CLS_LW;
            6'h2B:   cls = CLS_SW;
            default: cls = CLS_OTHER;
        endcase
        return cls;
    endfunction

    // State and pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= PC_RESET;
            valid_q <= 1'b0;
            instr_q <= '0;
            npc_q   <= '0;
            class_q <= CLS_RTYPE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            npc_q   <= npc_d;
            class_q <= class_d;
            count_q <= count_d;
        end
    end

    // Next state: redirect beats everything; stall only matters in RUN.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        npc_d   = npc_q;
        class_d = class_q;
        count_d = count_q;

        if (redirect_valid) begin
            state_d = ST_RUN;
            pc_d    = redirect_target;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (!stall) begin
                        if (pc_q < DEPTH_LIMIT) begin
                            instr_d = mem_data;
                            npc_d   = pc_q + XLEN'(1);
                            class_d = predecode(mem_data[31:26]);
                            valid_d = 1'b1;
                            count_d = count_q + CNT_W'(1);
                            pc_d    = pc_q + XLEN'(1);
                        end else begin
                            // PC ran off the end of memory: stop without capturing.
                            state_d = ST_HALT;
                            valid_d = 1'b0;
                        end
                    end
                end
                ST_HALT: begin
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    assign mem_addr    = pc_q;
    assign ifid_valid  = valid_q;
    assign ifid_instr  = instr_q;
    assign ifid_npc    = npc_q;
    assign ifid_class  = class_q;
    assign halted      = (state_q == ST_HALT);
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory model, behavioural reference, per-cycle
// compare plus directed scenarios with hand-computed literal expectations.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_npc;
    logic [2:0]  ifid_class;
    logic        halted;
    logic [15:0] fetch_count;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    logic [31:0] mem [0:127];

    instr_fetch #(.MEM_DEPTH(128), .RESET_PC(0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .ifid_valid     (ifid_valid),
        .ifid_instr     (ifid_instr),
        .ifid_npc       (ifid_npc),
        .ifid_class     (ifid_class),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    assign mem_data = (mem_addr < 32'd128) ? mem[mem_addr[6:0]] : 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural view of the fetch stage.
    logic [31:0] m_pc = 32'h0;
    bit          m_halt = 1'b0;
    bit          m_valid = 1'b0;
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_npc = 32'h0;
    logic [2:0]  m_class = 3'b000;
    logic [15:0] m_cnt = 16'h0;

    function automatic logic [2:0] class_of(input logic [31:0] w);
        logic [5:0] op;
        op = w[31:26];
        if (op == 6'h00) return 3'b000;
        if (op == 6'h04) return 3'b001;
        if (op == 6'h23) return 3'b010;
        if (op == 6'h2B) return 3'b011;
        return 3'b111;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 32'h0; m_halt = 1'b0; m_valid = 1'b0;
            m_instr = 32'h0; m_npc = 32'h0; m_class = 3'b000; m_cnt = 16'h0;
        end else if (redirect_valid) begin
            m_pc = redirect_target; m_valid = 1'b0; m_halt = 1'b0;
        end else if (m_halt || stall) begin
            if (m_halt) m_valid = 1'b0;
        end else if (m_pc >= 32'd128) begin
            m_halt = 1'b1; m_valid = 1'b0;
        end else begin
            m_instr = mem[m_pc[6:0]];
            m_class = class_of(m_instr);
            m_pc    = m_pc + 32'd1;
            m_npc   = m_pc;
            m_valid = 1'b1;
            m_cnt   = m_cnt + 16'd1;
        end
    end

    // Every cycle, away from the active edge, outputs must match the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("mdl_pc",    mem_addr,           m_pc);
            chk("mdl_valid", 32'(ifid_valid),    32'(m_valid));
            chk("mdl_instr", ifid_instr,         m_instr);
            chk("mdl_npc",   ifid_npc,           m_npc);
            chk("mdl_class", 32'(ifid_class),    32'(m_class));
            chk("mdl_halt",  32'(halted),        32'(m_halt));
            chk("mdl_count", 32'(fetch_count),   32'(m_cnt));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Asynchronous reset pulse between edges; outputs checked while low.
    task automatic reset_pulse(input string tag);
        @(negedge clk);
        stall = 1'b0; redirect_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_addr"},  mem_addr, 32'h0);
        chk({tag, "_valid"}, 32'(ifid_valid), 32'h0);
        chk({tag, "_instr"}, ifid_instr, 32'h0);
        chk({tag, "_npc"},   ifid_npc, 32'h0);
        chk({tag, "_class"}, 32'(ifid_class), 32'h0);
        chk({tag, "_halt"},  32'(halted), 32'h0);
        chk({tag, "_count"}, 32'(fetch_count), 32'h0);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        mem[0] = 32'h002300AA; mem[1] = 32'h10654321; mem[2] = 32'h00100022;
        mem[3] = 32'h8C123456; mem[4] = 32'h8F123456; mem[5] = 32'hAD654321;
        mem[6] = 32'h13012345; mem[7] = 32'hAC654321; mem[8] = 32'h12012345;
        mem[9] = 32'h08000000;
        for (int i = 10; i < 128; i++) mem[i] = 32'(i) * 32'h9E3779B1;

        // Power-on reset held across a couple of edges.
        #1 rst_n = 1'b0;
        #1;
        chk("por_addr",  mem_addr, 32'h0);
        chk("por_count", 32'(fetch_count), 32'h0);
        chk("por_halt",  32'(halted), 32'h0);
        tick(2);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // Free run from reset: first four captures.
        tick(1); chk("run1_instr", ifid_instr, 32'h002300AA); chk("run1_npc", ifid_npc, 32'd1);
                 chk("run1_class", 32'(ifid_class), 32'd0);
        tick(1); chk("run2_instr", ifid_instr, 32'h10654321); chk("run2_npc", ifid_npc, 32'd2);
                 chk("run2_class", 32'(ifid_class), 32'd1);
        tick(1); chk("run3_instr", ifid_instr, 32'h00100022); chk("run3_npc", ifid_npc, 32'd3);
                 chk("run3_class", 32'(ifid_class), 32'd0);
        tick(1); chk("run4_instr", ifid_instr, 32'h8C123456); chk("run4_npc", ifid_npc, 32'd4);
                 chk("run4_class", 32'(ifid_class), 32'd2);
        chk("run4_count", 32'(fetch_count), 32'd4);

        // Stall for three cycles after the second capture.
        reset_pulse("rst_a");
        tick(2);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("stall_addr",  mem_addr, 32'd2);
            chk("stall_instr", ifid_instr, 32'h10654321);
            chk("stall_count", 32'(fetch_count), 32'd2);
        end
        stall = 1'b0;
        tick(1); chk("unstall_instr", ifid_instr, 32'h00100022);

        // Redirect wins over stall, then capture at the target.
        redirect_valid = 1'b1; redirect_target = 32'd7; stall = 1'b1;
        tick(1); chk("redir_addr", mem_addr, 32'd7); chk("redir_valid", 32'(ifid_valid), 32'd0);
                 chk("redir_instr", ifid_instr, 32'h00100022);
        redirect_valid = 1'b0; stall = 1'b0;
        tick(1); chk("tgt_instr", ifid_instr, 32'hAC654321); chk("tgt_class", 32'(ifid_class), 32'd3);
                 chk("tgt_npc", ifid_npc, 32'd8);

        // End of memory: capture 126, 127, then halt; stall ignored while halted.
        redirect_valid = 1'b1; redirect_target = 32'd126;
        tick(1); redirect_valid = 1'b0;
        tick(1); chk("end126_npc", ifid_npc, 32'd127); chk("end126_valid", 32'(ifid_valid), 32'd1);
        tick(1); chk("end127_npc", ifid_npc, 32'd128);
        tick(1); chk("halt_flag", 32'(halted), 32'd1); chk("halt_valid", 32'(ifid_valid), 32'd0);
                 chk("halt_addr", mem_addr, 32'd128);
        stall = 1'b1;
        tick(2); chk("halt_stall", 32'(halted), 32'd1);
        stall = 1'b0;
        redirect_valid = 1'b1; redirect_target = 32'd0;
        tick(1); chk("unhalt_flag", 32'(halted), 32'd0); chk("unhalt_addr", mem_addr, 32'd0);
        redirect_valid = 1'b0;
        tick(1); chk("unhalt_instr", ifid_instr, 32'h002300AA);

        // Mid-run asynchronous reset, then a clean restart from address 0.
        tick(3);
        reset_pulse("rst_b");
        tick(1); chk("rst_b_first", ifid_instr, 32'h002300AA); chk("rst_b_cnt", 32'(fetch_count), 32'd1);

        // Unlisted opcode decodes to class 111.
        redirect_valid = 1'b1; redirect_target = 32'd9;
        tick(1); redirect_valid = 1'b0;
        tick(1); chk("other_instr", ifid_instr, 32'h08000000); chk("other_class", 32'(ifid_class), 32'd7);

        // Long run until the capture counter wraps; loop back at the end of memory.
        guard = 0;
        while (m_cnt != 16'hFFFF && guard < 80000) begin
            redirect_target = 32'd0;
            redirect_valid  = (m_pc >= 32'd128);
            tick(1);
            guard++;
        end
        chk("wrap_timeout_a", 32'(guard < 80000), 32'd1);
        chk("wrap_ffff", 32'(fetch_count), 32'h0000FFFF);
        guard = 0;
        while (m_cnt != 16'h0000 && guard < 300) begin
            redirect_target = 32'd0;
            redirect_valid  = (m_pc >= 32'd128);
            tick(1);
            guard++;
        end
        redirect_valid = 1'b0;
        chk("wrap_timeout_b", 32'(guard < 300), 32'd1);
        chk("wrap_zero", 32'(fetch_count), 32'h0);

        tick(1);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
